uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one `uart_tx` transmitter between `NUM_REQ` byte sources. It sits between several producers (command responder, status reporter, debug logger, and so on) and the single `uart_tx` instance that drives the serial pin. It accepts one byte at a time from the winning requester and launches it with a one-cycle `i_tx_dv` strobe. It then holds off all requesters until the transmitter reports done and an optional inter-frame gap has elapsed.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 36 +++
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, byte width and bit timing.
package uart_pkg;

    localparam int BYTE_W       = 8;
    localparam int CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        SEND,
        GAP
    } sched_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after i_ptr,
// wrapping at NUM_REQ, wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_win_oh,
    output logic [IDX_W-1:0]   o_win_idx,
    output logic               o_valid
);

    // Scan NUM_REQ positions starting at i_ptr; keep the first hit.
    always_comb begin
        int unsigned k;
        o_win_oh  = '0;
        o_win_idx = '0;
        o_valid   = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(i_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!o_valid && i_req[k]) begin
                o_valid     = 1'b1;
                o_win_oh[k] = 1'b1;
                o_win_idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte sources.
// Optional SEND watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = $clog2(NUM_REQ),
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 8192
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*BYTE_W-1:0] i_req_byte,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [IDX_W-1:0]          o_grant_id,
    output logic                      o_busy,
    output logic                      o_timeout,
    output logic                      o_tx_dv,
    output logic [BYTE_W-1:0]         o_tx_byte,
    input  logic                      i_tx_done
);

    localparam logic [15:0] GAP_LOAD = (GAP_CLKS > 0) ? 16'(GAP_CLKS - 1) : 16'd0;

    sched_state_t r_state;
    sched_state_t w_next;

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_win_idx;
    logic [NUM_REQ-1:0] r_win_oh;
    logic [BYTE_W-1:0]  r_tx_byte;
    logic [15:0]        r_gap_cnt;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_done_evt;
    logic               w_to_evt;
    logic               w_frame_end;
    logic [IDX_W-1:0]   w_ptr_next;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_pick_oh),
        .o_win_idx (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    assign w_done_evt  = (r_state == SEND) && i_tx_done;
    assign w_frame_end = w_done_evt || w_to_evt;
    assign w_ptr_next  = (r_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_win_idx + 1'b1;

`ifdef UART_SCHED_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CLKS - 1);

    logic [15:0] r_wd_cnt;
    logic        r_timeout;

    // Done has priority: a timeout only counts when no done arrives that cycle.
    assign w_to_evt  = (r_state == SEND) && !i_tx_done && (r_wd_cnt == WD_LIMIT);
    assign o_timeout = r_timeout;

    // Watchdog: cleared on launch, counts every SEND clock, pulses o_timeout once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_evt;
            if (r_state == LAUNCH) begin
                r_wd_cnt <= '0;
            end else if (r_state == SEND) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
        end
    end
`else
    assign w_to_evt  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_next = LAUNCH;
            LAUNCH:  w_next = SEND;
            SEND:    if (w_frame_end) w_next = (GAP_CLKS > 0) ? GAP : IDLE;
            GAP:     if (r_gap_cnt == 16'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Winner capture, round-robin pointer and inter-frame gap counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_win_idx <= '0;
            r_win_oh  <= '0;
            r_tx_byte <= '0;
            r_gap_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && w_pick_valid) begin
                r_win_idx <= w_pick_idx;
                r_win_oh  <= w_pick_oh;
                r_tx_byte <= i_req_byte[w_pick_idx*BYTE_W +: BYTE_W];
            end
            if (w_frame_end) begin
                r_ptr     <= w_ptr_next;
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == GAP) && (r_gap_cnt != 16'd0)) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end
        end
    end

    assign o_tx_dv    = (r_state == LAUNCH);
    assign o_grant    = (r_state == LAUNCH) ? r_win_oh : '0;
    assign o_grant_id = r_win_idx;
    assign o_busy     = (r_state != IDLE);
    assign o_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched; the transmitter's done pulse is driven by hand.
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int GAP     = 100;
    localparam int TO_CLKS = 5000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_byte;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_id;
    logic                 busy;
    logic                 timeout;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_done;

    int n_checks   = 0;
    int n_errors   = 0;
    int n_to_pulse = 0;

    uart_tx_sched #(
        .NUM_REQ      (NUM_REQ),
        .IDX_W        (IDX_W),
        .GAP_CLKS     (GAP),
        .TIMEOUT_CLKS (TO_CLKS)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_req_byte (req_byte),
        .o_grant    (grant),
        .o_grant_id (grant_id),
        .o_busy     (busy),
        .o_timeout  (timeout),
        .o_tx_dv    (tx_dv),
        .o_tx_byte  (tx_byte),
        .i_tx_done  (tx_done)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (timeout) n_to_pulse++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_dv(input string tag);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx_dv) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_dv_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic expect_launch(input string tag, input int id, input logic [7:0] b);
        check({tag, "_dv"},    32'(tx_dv),    32'd1);
        check({tag, "_grant"}, 32'(grant),    32'(1 << id));
        check({tag, "_id"},    32'(grant_id), 32'(id));
        check({tag, "_byte"},  32'(tx_byte),  32'(b));
        check({tag, "_busy"},  32'(busy),     32'd1);
    endtask

    // Entered on the LAUNCH cycle. Pulses done after a few SEND cycles, then
    // counts busy-high cycles after done and where the next launch (if any) lands.
    task automatic finish_frame(output int gap_high, output int dv_at);
        bit seen_low = 0;
        gap_high = 0;
        dv_at    = 0;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            if (k > 1) @(negedge clk);
            if (tx_dv) begin
                dv_at = k;
                break;
            end
            if (busy && !seen_low) gap_high++;
            else seen_low = 1;
        end
    endtask

    int gh, da;
    int ids[5]  = '{0, 1, 2, 3, 0};
    int bts[5]  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

    initial begin
        req_byte = '0;
        do_reset();

        // Reset values
        check("rst_grant",   32'(grant),    32'd0);
        check("rst_id",      32'(grant_id), 32'd0);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_timeout", 32'(timeout),  32'd0);
        check("rst_dv",      32'(tx_dv),    32'd0);
        check("rst_byte",    32'(tx_byte),  32'd0);

        // Single request, one-cycle latency
        req_byte = 32'h00AB_0000;
        req      = 4'b0100;
        @(negedge clk);
        expect_launch("single", 2, 8'hAB);
        @(negedge clk);
        req = '0;
        check("single_send_dv",   32'(tx_dv),   32'd0);
        check("single_send_byte", 32'(tx_byte), 32'hAB);
        finish_frame(gh, da);
        check("single_gap_busy", 32'(gh), 32'(GAP));
        check("single_no_next",  32'(da), 32'd0);

        // Stray done in IDLE is ignored
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("stray_busy", 32'(busy),  32'd0);
        check("stray_dv",   32'(tx_dv), 32'd0);

        // ptr=3: requesters 0,1 pending -> 0 wins; request churn during SEND ignored
        req_byte = 32'h0077_6655;
        req      = 4'b0011;
        wait_dv("rr3");
        expect_launch("rr3", 0, 8'h55);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        req = 4'b0100;
        begin
            int bad = 0;
            repeat (3) begin
                @(negedge clk);
                if (grant != '0 || tx_dv) bad++;
            end
            check("ignore_req_in_send", 32'(bad), 32'd0);
        end
        finish_frame(gh, da);
        check("ignore_next_at", 32'(da), 32'(GAP + 2));
        expect_launch("ignore_next", 2, 8'h77);
        req = '0;
        finish_frame(gh, da);

        // Reset mid-frame
        req_byte = 32'h3F00_0000;
        req      = 4'b1000;
        wait_dv("mid");
        expect_launch("mid", 3, 8'h3F);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("mid_send_byte", 32'(tx_byte), 32'h3F);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {grant, 6'(grant_id), busy, timeout, tx_dv, tx_byte}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        req_byte = 32'h4400_5A00;
        req      = 4'b1010;
        wait_dv("post_rst");
        expect_launch("post_rst", 1, 8'h5A);
        req = '0;
        finish_frame(gh, da);

        // Fairness: all four held, served 0,1,2,3 then 0 again
        do_reset();
        req_byte = 32'h4332_2110;
        req      = 4'b1111;
        wait_dv("fair0");
        for (int i = 0; i < 5; i++) begin
            expect_launch($sformatf("fair%0d", i), ids[i], 8'(bts[i]));
            if (i == 4) req = '0;
            finish_frame(gh, da);
            if (i < 4) begin
                check($sformatf("fair%0d_gap", i),  32'(gh), 32'(GAP));
                check($sformatf("fair%0d_next", i), 32'(da), 32'(GAP + 2));
            end else begin
                check("fair_end_idle", 32'(busy), 32'd0);
            end
        end

`ifdef UART_SCHED_TIMEOUT_EN
        // Watchdog: done never arrives
        req_byte = 32'h0000_00C3;
        req      = 4'b0001;
        wait_dv("to");
        expect_launch("to", 0, 8'hC3);
        begin
            int k;
            for (k = 1; k <= TO_CLKS + 20; k++) begin
                @(negedge clk);
                if (timeout) break;
            end
            check("to_latency", 32'(k - 1), 32'(TO_CLKS));
            @(negedge clk);
            check("to_pulse_width", 32'(timeout), 32'd0);
        end
        req_byte = 32'h0000_E7D6;
        req      = 4'b0011;
        wait_dv("after_to");
        expect_launch("after_to", 1, 8'hE7);
        req = '0;
        check("to_pulse_count", 32'(n_to_pulse), 32'd1);
`else
        check("no_timeout_pulses", 32'(n_to_pulse), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
